// File: rtl/riscv_regfile_wb_scheduler_if.sv
// Writeback / scoreboard bundle for riscv_regfile_wb_scheduler.
// Groups the two writeback request channels, the issue-stage scoreboard
// query/update signals and the single register-file write port.
//   alu_wb_*      : ALU writeback request (valid/ready/addr/data)
//   lsu_wb_*      : LSU (load) writeback request (valid/ready/addr/data)
//   issue_*       : destination register of a newly issued instruction
//   rs1/rs2_*     : source-operand pending queries from the issue stage
//   rd_*          : registered write port towards the register file
// The scheduler uses the slave modport. The execute/LSU/issue side,
// or a testbench, uses the master modport.
interface riscv_regfile_wb_scheduler_if;
    logic        alu_wb_valid;
    logic        alu_wb_ready;
    logic [4:0]  alu_wb_addr;
    logic [31:0] alu_wb_data;

    logic        lsu_wb_valid;
    logic        lsu_wb_ready;
    logic [4:0]  lsu_wb_addr;
    logic [31:0] lsu_wb_data;

    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_pending;
    logic        rs2_pending;

    logic        rd_write;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    modport master (
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  alu_wb_ready, lsu_wb_ready,
        input  rs1_pending, rs2_pending,
        input  rd_write, rd_addr, rd_data
    );

    modport slave (
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        output alu_wb_ready, lsu_wb_ready,
        output rs1_pending, rs2_pending,
        output rd_write, rd_addr, rd_data
    );
endinterface

// File: rtl/riscv_regfile_wb_scheduler.sv
// riscv_regfile_wb_scheduler
// Shares the register file's single write port between the ALU and LSU
// writeback paths, and keeps a per-register pending scoreboard so that the
// issue stage can stall dependent instructions until their producer commits.
// Ports:
//   clk      : single clock, all state on posedge
//   reset_n  : asynchronous active-low reset
//   wb       : riscv_regfile_wb_scheduler_if.slave
//              - alu_wb_* / lsu_wb_* : writeback requests, ready is combinational
//              - issue_valid/issue_rd: marks a destination register pending
//              - rs1/rs2_addr -> rs1/rs2_pending : combinational lookup
//              - rd_write/rd_addr/rd_data : registered write port (latency 1)
// Arbitration is fixed-priority LSU. A saturating starvation counter hands
// priority to the ALU once it has been refused MAX_WAIT consecutive cycles.
module riscv_regfile_wb_scheduler #(
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    riscv_regfile_wb_scheduler_if.slave   wb
);

    localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

    // Starvation counter and its next value
    logic [CNT_W-1:0] starve_cnt_r;
    logic [CNT_W-1:0] starve_cnt_next_s;

    // Arbitration signals
    logic        alu_prio_s;
    logic        alu_ready_s;
    logic        lsu_ready_s;
    logic        alu_acc_s;
    logic        lsu_acc_s;
    logic [1:0]  win_sel_s;
    logic        any_acc_s;
    logic [4:0]  win_addr_s;
    logic [31:0] win_data_s;
    logic        commit_s;

    // Registered write port
    logic        rd_write_r;
    logic [4:0]  rd_addr_r;
    logic [31:0] rd_data_r;

    // Scoreboard; x0 is never tracked, so only bits 31..1 are stored
    logic [31:1] pending_r;
    logic [31:1] pending_next_s;
    logic [31:0] pending_full_s;
    logic        rs1_pending_s;
    logic        rs2_pending_s;

    // Arbitration: readies depend only on the other requester's valid, so
    // the two accepts are mutually exclusive by construction.
    always_comb begin
        alu_prio_s  = (starve_cnt_r == MAX_WAIT_C);
        lsu_ready_s = ~(wb.alu_wb_valid & alu_prio_s);
        alu_ready_s = ~(wb.lsu_wb_valid & ~alu_prio_s);
        lsu_acc_s   = wb.lsu_wb_valid & lsu_ready_s;
        alu_acc_s   = wb.alu_wb_valid & alu_ready_s;
        any_acc_s   = lsu_acc_s | alu_acc_s;
        win_sel_s   = {lsu_acc_s, alu_acc_s};
        win_addr_s  = 5'd0;
        win_data_s  = 32'd0;
        case (win_sel_s)
            2'b10: begin
                win_addr_s = wb.lsu_wb_addr;
                win_data_s = wb.lsu_wb_data;
            end
            2'b01: begin
                win_addr_s = wb.alu_wb_addr;
                win_data_s = wb.alu_wb_data;
            end
            default: begin
                win_addr_s = 5'd0;
                win_data_s = 32'd0;
            end
        endcase
        // A write to x0 completes the handshake but is not committed.
        commit_s = any_acc_s & (win_addr_s != 5'd0);
    end

    // Starvation counter next state: count refusals, saturate, clear otherwise
    always_comb begin
        starve_cnt_next_s = CNT_ZERO_C;
        if (wb.alu_wb_valid && !alu_ready_s) begin
            if (starve_cnt_r == MAX_WAIT_C) begin
                starve_cnt_next_s = starve_cnt_r;
            end else begin
                starve_cnt_next_s = starve_cnt_r + CNT_ONE_C;
            end
        end else begin
            starve_cnt_next_s = CNT_ZERO_C;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_r <= CNT_ZERO_C;
        end else begin
            starve_cnt_r <= starve_cnt_next_s;
        end
    end

    // Write-port output stage; address/data hold while no write is committed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_write_r <= 1'b0;
            rd_addr_r  <= 5'd0;
            rd_data_r  <= 32'd0;
        end else begin
            rd_write_r <= commit_s;
            if (commit_s) begin
                rd_addr_r <= win_addr_s;
                rd_data_r <= win_data_s;
            end
        end
    end

    // Scoreboard next state: the clear comes from the write the regfile
    // commits this edge; a same-cycle issue to that register is a newer
    // producer, so set overrides clear.
    always_comb begin
        pending_next_s = pending_r;
        for (int i = 1; i < 32; i++) begin
            if (wb.issue_valid && (wb.issue_rd == 5'(i))) begin
                pending_next_s[i] = 1'b1;
            end else if (rd_write_r && (rd_addr_r == 5'(i))) begin
                pending_next_s[i] = 1'b0;
            end else begin
                pending_next_s[i] = pending_r[i];
            end
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= 31'd0;
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // Source-operand lookup; bit 0 is tied low so x0 never reads as pending
    always_comb begin
        pending_full_s = {pending_r, 1'b0};
        rs1_pending_s  = pending_full_s[wb.rs1_addr];
        rs2_pending_s  = pending_full_s[wb.rs2_addr];
    end

    assign wb.alu_wb_ready = alu_ready_s;
    assign wb.lsu_wb_ready = lsu_ready_s;
    assign wb.rs1_pending  = rs1_pending_s;
    assign wb.rs2_pending  = rs2_pending_s;
    assign wb.rd_write     = rd_write_r;
    assign wb.rd_addr      = rd_addr_r;
    assign wb.rd_data      = rd_data_r;

endmodule

// File: tb/tb_riscv_regfile_wb_scheduler.sv
// Self-checking bench for riscv_regfile_wb_scheduler. Expected register
// writes are queued as requests are driven and popped by a monitor on the
// falling edge whenever rd_write is seen.
module tb_riscv_regfile_wb_scheduler;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    riscv_regfile_wb_scheduler_if bus ();

    riscv_regfile_wb_scheduler #(.MAX_WAIT(3), .CNT_W(4)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wb      (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [36:0] exp_q[$];
    logic [36:0] mon_e;

    // Monitor: every committed write must match the oldest expected write
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.rd_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0d data=%08h, expected no write",
                         bus.rd_addr, bus.rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.rd_addr, bus.rd_data} !== mon_e) begin
                    failures++;
                    $display("FAIL write_order got addr=%0d data=%08h, expected addr=%0d data=%08h",
                             bus.rd_addr, bus.rd_data, mon_e[36:32], mon_e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_wb_valid = 1'b0;
        bus.alu_wb_addr  = 5'd0;
        bus.alu_wb_data  = 32'd0;
        bus.lsu_wb_valid = 1'b0;
        bus.lsu_wb_addr  = 5'd0;
        bus.lsu_wb_data  = 32'd0;
        bus.issue_valid  = 1'b0;
        bus.issue_rd     = 5'd0;
    endtask

    task automatic test_reset();
        int bad;
        reset_n      = 1'b0;
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        idle();
        tick();
        checks++;
        if ({bus.rd_write, bus.rd_addr, bus.rd_data} !== 38'd0) begin
            failures++;
            $display("FAIL reset_outputs got %b/%0d/%08h, expected 0/0/00000000",
                     bus.rd_write, bus.rd_addr, bus.rd_data);
        end
        tick();
        reset_n = 1'b1;
        // Mid-stream: set a pending bit and get a write in flight, then reset
        tick();
        bus.issue_valid  = 1'b1;
        bus.issue_rd     = 5'd9;
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_addr  = 5'd9;
        bus.alu_wb_data  = 32'hA5A5_A5A5;
        tick();
        idle();
        bus.rs1_addr = 5'd9;
        #1;
        checks++;
        if (bus.rd_write !== 1'b1 || bus.rs1_pending !== 1'b1) begin
            failures++;
            $display("FAIL reset_inflight_setup got rd_write=%b pending=%b, expected 1/1",
                     bus.rd_write, bus.rs1_pending);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.rd_write, bus.rd_addr, bus.rd_data} !== 38'd0) begin
            failures++;
            $display("FAIL reset_midstream got %b/%0d/%08h, expected 0/0/00000000",
                     bus.rd_write, bus.rd_addr, bus.rd_data);
        end
        checks++;
        if (bus.alu_wb_ready !== 1'b1 || bus.lsu_wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_readies got alu=%b lsu=%b, expected 1/1",
                     bus.alu_wb_ready, bus.lsu_wb_ready);
        end
        bad = 0;
        for (int a = 0; a < 32; a++) begin
            bus.rs1_addr = 5'(a);
            #1;
            if (bus.rs1_pending !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_pending got %0d pending regs, expected 0", bad);
        end
        tick();
        reset_n = 1'b1;
        bus.rs1_addr = 5'd0;
    endtask

    task automatic test_solo_alu();
        tick();
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_addr  = 5'd5;
        bus.alu_wb_data  = 32'hDEAD_BEEF;
        exp_q.push_back({5'd5, 32'hDEAD_BEEF});
        #1;
        checks++;
        if (bus.alu_wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL solo_alu_ready got %b, expected 1", bus.alu_wb_ready);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.rd_write !== 1'b1 || bus.rd_addr !== 5'd5 || bus.rd_data !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL solo_alu_write got %b/%0d/%08h, expected 1/5/deadbeef",
                     bus.rd_write, bus.rd_addr, bus.rd_data);
        end
        tick();
        checks++;
        if (bus.rd_write !== 1'b0 || bus.rd_addr !== 5'd5) begin
            failures++;
            $display("FAIL solo_alu_hold got rd_write=%b addr=%0d, expected 0/5",
                     bus.rd_write, bus.rd_addr);
        end
    endtask

    task automatic test_collision();
        tick();
        bus.lsu_wb_valid = 1'b1;
        bus.lsu_wb_addr  = 5'd3;
        bus.lsu_wb_data  = 32'h0000_0011;
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_addr  = 5'd4;
        bus.alu_wb_data  = 32'h0000_0022;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.lsu_wb_ready !== 1'b1 || bus.alu_wb_ready !== 1'b0) begin
                failures++;
                $display("FAIL collision_lsu_wins cycle=%0d got lsu=%b alu=%b, expected 1/0",
                         i, bus.lsu_wb_ready, bus.alu_wb_ready);
            end
            exp_q.push_back({5'd3, 32'h0000_0011});
            tick();
        end
        #1;
        checks++;
        if (bus.alu_wb_ready !== 1'b1 || bus.lsu_wb_ready !== 1'b0) begin
            failures++;
            $display("FAIL collision_alu_prio got alu=%b lsu=%b, expected 1/0",
                     bus.alu_wb_ready, bus.lsu_wb_ready);
        end
        exp_q.push_back({5'd4, 32'h0000_0022});
        tick();
        // New ALU request: counter must be back at 0, so LSU wins again
        bus.alu_wb_addr = 5'd6;
        bus.alu_wb_data = 32'h0000_0033;
        #1;
        checks++;
        if (bus.alu_wb_ready !== 1'b0 || bus.lsu_wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL collision_cnt_cleared got alu=%b lsu=%b, expected 0/1",
                     bus.alu_wb_ready, bus.lsu_wb_ready);
        end
        exp_q.push_back({5'd3, 32'h0000_0011});
        tick();
        idle();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL collision_drain got %0d outstanding writes, expected 0", exp_q.size());
        end
    endtask

    task automatic test_scoreboard();
        tick();
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.rs1_addr    = 5'd7;
        bus.rs2_addr    = 5'd8;
        #1;
        checks++;
        if (bus.rs1_pending !== 1'b0) begin
            failures++;
            $display("FAIL sb_no_bypass got %b, expected 0", bus.rs1_pending);
        end
        tick();
        bus.issue_valid = 1'b0;
        #1;
        checks++;
        if (bus.rs1_pending !== 1'b1 || bus.rs2_pending !== 1'b0) begin
            failures++;
            $display("FAIL sb_set got rs1=%b rs2=%b, expected 1/0", bus.rs1_pending, bus.rs2_pending);
        end
        tick();
        bus.lsu_wb_valid = 1'b1;
        bus.lsu_wb_addr  = 5'd7;
        bus.lsu_wb_data  = 32'h0000_0077;
        exp_q.push_back({5'd7, 32'h0000_0077});
        tick();
        bus.lsu_wb_valid = 1'b0;
        #1;
        checks++;
        if (bus.rd_write !== 1'b1 || bus.rd_addr !== 5'd7 || bus.rs1_pending !== 1'b1) begin
            failures++;
            $display("FAIL sb_during_write got rd_write=%b addr=%0d pending=%b, expected 1/7/1",
                     bus.rd_write, bus.rd_addr, bus.rs1_pending);
        end
        tick();
        checks++;
        if (bus.rs1_pending !== 1'b0) begin
            failures++;
            $display("FAIL sb_clear got %b, expected 0", bus.rs1_pending);
        end
        // Same-cycle set and clear of x7: set must win
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        tick();
        bus.issue_valid  = 1'b0;
        bus.lsu_wb_valid = 1'b1;
        bus.lsu_wb_data  = 32'h0000_0078;
        exp_q.push_back({5'd7, 32'h0000_0078});
        tick();
        bus.lsu_wb_valid = 1'b0;
        bus.issue_valid  = 1'b1;
        #1;
        checks++;
        if (bus.rd_write !== 1'b1 || bus.rd_addr !== 5'd7) begin
            failures++;
            $display("FAIL sb_same_setup got rd_write=%b addr=%0d, expected 1/7", bus.rd_write, bus.rd_addr);
        end
        tick();
        bus.issue_valid = 1'b0;
        #1;
        checks++;
        if (bus.rs1_pending !== 1'b1) begin
            failures++;
            $display("FAIL sb_set_wins got %b, expected 1", bus.rs1_pending);
        end
        bus.lsu_wb_valid = 1'b1;
        bus.lsu_wb_data  = 32'h0000_0079;
        exp_q.push_back({5'd7, 32'h0000_0079});
        tick();
        bus.lsu_wb_valid = 1'b0;
        tick();
        checks++;
        if (bus.rs1_pending !== 1'b0) begin
            failures++;
            $display("FAIL sb_final_clear got %b, expected 0", bus.rs1_pending);
        end
        idle();
    endtask

    task automatic test_x0();
        tick();
        bus.lsu_wb_valid = 1'b1;
        bus.lsu_wb_addr  = 5'd0;
        bus.lsu_wb_data  = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (bus.lsu_wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL x0_ready got %b, expected 1", bus.lsu_wb_ready);
        end
        tick();
        bus.lsu_wb_valid = 1'b0;
        bus.issue_valid  = 1'b1;
        bus.issue_rd     = 5'd0;
        #1;
        checks++;
        if (bus.rd_write !== 1'b0) begin
            failures++;
            $display("FAIL x0_no_write got %b, expected 0", bus.rd_write);
        end
        tick();
        bus.issue_valid = 1'b0;
        bus.rs1_addr    = 5'd0;
        #1;
        checks++;
        if (bus.rs1_pending !== 1'b0) begin
            failures++;
            $display("FAIL x0_pending got %b, expected 0", bus.rs1_pending);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        tick();
        for (int i = 1; i <= 4; i++) begin
            bus.lsu_wb_valid = 1'b1;
            bus.lsu_wb_addr  = 5'(i);
            bus.lsu_wb_data  = 32'h0000_0100 + 32'(i);
            exp_q.push_back({5'(i), 32'h0000_0100 + 32'(i)});
            if (i > 1) begin
                #1;
                checks++;
                if (bus.rd_write !== 1'b1 || bus.rd_addr !== 5'(i - 1)) begin
                    failures++;
                    $display("FAIL b2b_write step=%0d got rd_write=%b addr=%0d, expected 1/%0d",
                             i, bus.rd_write, bus.rd_addr, i - 1);
                end
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (bus.rd_write !== 1'b1 || bus.rd_addr !== 5'd4) begin
            failures++;
            $display("FAIL b2b_last got rd_write=%b addr=%0d, expected 1/4", bus.rd_write, bus.rd_addr);
        end
        tick();
        checks++;
        if (bus.rd_write !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got %b, expected 0", bus.rd_write);
        end
    endtask

    initial begin
        test_reset();
        test_solo_alu();
        test_collision();
        test_scoreboard();
        test_x0();
        test_back_to_back();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL final_drain got %0d outstanding writes, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
